// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared configuration for the pipeline hazard sequencer: widths and FSM encodings.
package pipe_hazard_ctrl_pkg;

    localparam int HZ_CPU_WIDTH = 64;
    localparam int HZ_REG_ADDRW = 5;
    localparam int HZ_CNT_W     = 32;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1
    } hz_state_e;

endpackage

// File: rtl/hz_perf_cnt.sv
// Wrapping, enabled performance counter with asynchronous active-low reset.
module hz_perf_cnt
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int W = HZ_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_r;

    // Count enabled cycles; natural overflow gives the modulo wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (i_en) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_cnt = cnt_r;

endmodule

// File: rtl/pipe_hazard_ctrl_chk.sv
// Protocol checker: a new EX redirect must never arrive while one is still pending.
module pipe_hazard_ctrl_chk (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_ex_redirect,
    input logic i_pend_v
);

    // EX is frozen while a redirect is held, so a second pulse means upstream misbehaved.
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(i_ex_redirect && i_pend_v));
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: load-use bubbles, memory-wait stalls, branch redirects
// (held across a memory stall) and stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CPU_WIDTH = HZ_CPU_WIDTH,
    parameter int REG_ADDRW = HZ_REG_ADDRW,
    parameter int CNT_W     = HZ_CNT_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_id_valid,
    input  logic [REG_ADDRW-1:0] i_id_rs1id,
    input  logic                 i_id_rs1en,
    input  logic [REG_ADDRW-1:0] i_id_rs2id,
    input  logic                 i_id_rs2en,
    input  logic                 i_ex_valid,
    input  logic [REG_ADDRW-1:0] i_ex_rdid,
    input  logic                 i_ex_rdwen,
    input  logic                 i_ex_lden,
    input  logic                 i_ex_redirect,
    input  logic [CPU_WIDTH-1:0] i_ex_redirect_pc,
    input  logic                 i_mem_req,
    input  logic                 i_mem_ack,
    output logic                 o_pc_stall,
    output logic                 o_ifid_stall,
    output logic                 o_ifid_flush,
    output logic                 o_idex_bubble,
    output logic                 o_exmem_stall,
    output logic                 o_redirect_valid,
    output logic [CPU_WIDTH-1:0] o_redirect_pc,
    output logic [CNT_W-1:0]     o_stall_cnt,
    output logic [CNT_W-1:0]     o_flush_cnt,
    output logic [1:0]           o_state
);

    hz_state_e            state_r;
    hz_state_e            state_nxt_s;
    logic                 pend_v_r;
    logic [CPU_WIDTH-1:0] pend_pc_r;

    logic                 mem_stall_s;
    logic                 rs1_hit_s;
    logic                 rs2_hit_s;
    logic                 load_use_s;
    logic                 redir_s;
    logic [CPU_WIDTH-1:0] target_s;

    logic                 pc_stall_s;
    logic                 ifid_stall_s;
    logic                 ifid_flush_s;
    logic                 idex_bubble_s;
    logic                 exmem_stall_s;
    logic                 redir_valid_s;
    logic [CPU_WIDTH-1:0] redir_pc_s;

    // A same-cycle ack is a hit and never stalls; MEM_WAIT only listens to the ack.
    assign mem_stall_s = ((state_r == HZ_RUN) & i_mem_req & ~i_mem_ack) |
                         ((state_r == HZ_MEM_WAIT) & ~i_mem_ack);

    assign rs1_hit_s  = i_id_rs1en & (i_id_rs1id == i_ex_rdid);
    assign rs2_hit_s  = i_id_rs2en & (i_id_rs2id == i_ex_rdid);
    assign load_use_s = i_id_valid & i_ex_valid & i_ex_lden & i_ex_rdwen &
                        (i_ex_rdid != {REG_ADDRW{1'b0}}) & (rs1_hit_s | rs2_hit_s);

    assign redir_s  = i_ex_redirect | pend_v_r;
    assign target_s = pend_v_r ? pend_pc_r : i_ex_redirect_pc;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= HZ_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic for the data-memory wait FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            HZ_RUN: begin
                if (i_mem_req && !i_mem_ack) begin
                    state_nxt_s = HZ_MEM_WAIT;
                end else begin
                    state_nxt_s = HZ_RUN;
                end
            end
            HZ_MEM_WAIT: begin
                if (i_mem_ack) begin
                    state_nxt_s = HZ_RUN;
                end else begin
                    state_nxt_s = HZ_MEM_WAIT;
                end
            end
            default: state_nxt_s = HZ_RUN;
        endcase
    end

    // Prioritised control outputs; a redirect wins over load-use because the user is flushed.
    always_comb begin
        pc_stall_s    = 1'b0;
        ifid_stall_s  = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        exmem_stall_s = 1'b0;
        redir_valid_s = 1'b0;
        redir_pc_s    = {CPU_WIDTH{1'b0}};
        if (!i_rst_n) begin
            pc_stall_s = 1'b0;
        end else if (mem_stall_s) begin
            pc_stall_s    = 1'b1;
            ifid_stall_s  = 1'b1;
            exmem_stall_s = 1'b1;
        end else if (redir_s) begin
            redir_valid_s = 1'b1;
            redir_pc_s    = target_s;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else if (load_use_s) begin
            pc_stall_s    = 1'b1;
            ifid_stall_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else begin
            pc_stall_s = 1'b0;
        end
    end

    // Hold a redirect that lands during a memory stall until the stall releases.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_v_r  <= 1'b0;
            pend_pc_r <= {CPU_WIDTH{1'b0}};
        end else if (mem_stall_s && i_ex_redirect) begin
            pend_v_r  <= 1'b1;
            pend_pc_r <= i_ex_redirect_pc;
        end else if (redir_valid_s) begin
            pend_v_r  <= 1'b0;
            pend_pc_r <= {CPU_WIDTH{1'b0}};
        end else begin
            pend_v_r  <= pend_v_r;
            pend_pc_r <= pend_pc_r;
        end
    end

    hz_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (pc_stall_s),
        .o_cnt   (o_stall_cnt)
    );

    hz_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (redir_valid_s),
        .o_cnt   (o_flush_cnt)
    );

    pipe_hazard_ctrl_chk u_chk (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_ex_redirect (i_ex_redirect),
        .i_pend_v      (pend_v_r)
    );

    assign o_pc_stall       = pc_stall_s;
    assign o_ifid_stall     = ifid_stall_s;
    assign o_ifid_flush     = ifid_flush_s;
    assign o_idex_bubble    = idex_bubble_s;
    assign o_exmem_stall    = exmem_stall_s;
    assign o_redirect_valid = redir_valid_s;
    assign o_redirect_pc    = redir_pc_s;
    assign o_state          = state_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: expectations are queued as each
// cycle's stimulus is driven and compared mid-cycle against the DUT outputs.
module tb_pipe_hazard_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_id_valid;
    logic [4:0]  i_id_rs1id;
    logic        i_id_rs1en;
    logic [4:0]  i_id_rs2id;
    logic        i_id_rs2en;
    logic        i_ex_valid;
    logic [4:0]  i_ex_rdid;
    logic        i_ex_rdwen;
    logic        i_ex_lden;
    logic        i_ex_redirect;
    logic [63:0] i_ex_redirect_pc;
    logic        i_mem_req;
    logic        i_mem_ack;
    logic        o_pc_stall;
    logic        o_ifid_stall;
    logic        o_ifid_flush;
    logic        o_idex_bubble;
    logic        o_exmem_stall;
    logic        o_redirect_valid;
    logic [63:0] o_redirect_pc;
    logic [31:0] o_stall_cnt;
    logic [31:0] o_flush_cnt;
    logic [1:0]  o_state;

    typedef struct {
        logic        pcs;
        logic        ifs;
        logic        fl;
        logic        bub;
        logic        exm;
        logic        rv;
        logic [63:0] rpc;
        logic [31:0] scnt;
        logic [31:0] fcnt;
        logic [1:0]  st;
    } exp_t;

    exp_t        sb_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_scnt = 32'd0;
    logic [31:0] exp_fcnt = 32'd0;

    always #5 i_clk = ~i_clk;

    pipe_hazard_ctrl #(.CPU_WIDTH(64), .REG_ADDRW(5), .CNT_W(32)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_id_valid       (i_id_valid),
        .i_id_rs1id       (i_id_rs1id),
        .i_id_rs1en       (i_id_rs1en),
        .i_id_rs2id       (i_id_rs2id),
        .i_id_rs2en       (i_id_rs2en),
        .i_ex_valid       (i_ex_valid),
        .i_ex_rdid        (i_ex_rdid),
        .i_ex_rdwen       (i_ex_rdwen),
        .i_ex_lden        (i_ex_lden),
        .i_ex_redirect    (i_ex_redirect),
        .i_ex_redirect_pc (i_ex_redirect_pc),
        .i_mem_req        (i_mem_req),
        .i_mem_ack        (i_mem_ack),
        .o_pc_stall       (o_pc_stall),
        .o_ifid_stall     (o_ifid_stall),
        .o_ifid_flush     (o_ifid_flush),
        .o_idex_bubble    (o_idex_bubble),
        .o_exmem_stall    (o_exmem_stall),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .o_stall_cnt      (o_stall_cnt),
        .o_flush_cnt      (o_flush_cnt),
        .o_state          (o_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        i_id_valid       = 1'b0;
        i_id_rs1id       = 5'd0;
        i_id_rs1en       = 1'b0;
        i_id_rs2id       = 5'd0;
        i_id_rs2en       = 1'b0;
        i_ex_valid       = 1'b0;
        i_ex_rdid        = 5'd0;
        i_ex_rdwen       = 1'b0;
        i_ex_lden        = 1'b0;
        i_ex_redirect    = 1'b0;
        i_ex_redirect_pc = 64'd0;
        i_mem_req        = 1'b0;
        i_mem_ack        = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic en1,
                                input logic [4:0] rs2, input logic en2);
        i_id_valid = 1'b1;
        i_id_rs1id = rs1;
        i_id_rs1en = en1;
        i_id_rs2id = rs2;
        i_id_rs2en = en2;
        i_ex_valid = 1'b1;
        i_ex_rdid  = rd;
        i_ex_rdwen = 1'b1;
        i_ex_lden  = 1'b1;
    endtask

    // Queue this cycle's expectation; counters show events of earlier cycles only.
    task automatic push(input logic pcs, input logic ifs, input logic fl, input logic bub,
                        input logic exm, input logic rv, input logic [63:0] rpc,
                        input logic [1:0] st);
        exp_t e;
        e.pcs  = pcs;
        e.ifs  = ifs;
        e.fl   = fl;
        e.bub  = bub;
        e.exm  = exm;
        e.rv   = rv;
        e.rpc  = rpc;
        e.scnt = exp_scnt;
        e.fcnt = exp_fcnt;
        e.st   = st;
        sb_q.push_back(e);
        if (pcs) exp_scnt = exp_scnt + 32'd1;
        if (rv)  exp_fcnt = exp_fcnt + 32'd1;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".pc_stall"},    64'(o_pc_stall),       64'(e.pcs));
            chk({tag, ".ifid_stall"},  64'(o_ifid_stall),     64'(e.ifs));
            chk({tag, ".ifid_flush"},  64'(o_ifid_flush),     64'(e.fl));
            chk({tag, ".idex_bubble"}, 64'(o_idex_bubble),    64'(e.bub));
            chk({tag, ".exmem_stall"}, 64'(o_exmem_stall),    64'(e.exm));
            chk({tag, ".redir_valid"}, 64'(o_redirect_valid), 64'(e.rv));
            chk({tag, ".redir_pc"},    o_redirect_pc,         e.rpc);
            chk({tag, ".stall_cnt"},   64'(o_stall_cnt),      64'(e.scnt));
            chk({tag, ".flush_cnt"},   64'(o_flush_cnt),      64'(e.fcnt));
            chk({tag, ".state"},       64'(o_state),          64'(e.st));
        end
    endtask

    // Inputs are already driven just after a rising edge; sample mid-cycle, then advance.
    task automatic step(input string tag, input logic pcs, input logic ifs, input logic fl,
                        input logic bub, input logic exm, input logic rv,
                        input logic [63:0] rpc, input logic [1:0] st);
        push(pcs, ifs, fl, bub, exm, rv, rpc, st);
        #4;
        pop_check(tag);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // Reset held with aggressive inputs: every control output must stay low.
        clear_in();
        i_rst_n          = 1'b0;
        i_mem_req        = 1'b1;
        i_ex_redirect    = 1'b1;
        i_ex_redirect_pc = 64'h0000_0000_8000_0100;
        set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #6;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);
        #4;
        pop_check("reset");
        #2;
        clear_in();
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        step("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);

        set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        step("lu_rs1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 2'd0);
        clear_in();
        step("lu_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);
        set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        step("lu_x0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);
        set_load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        step("lu_rs2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 2'd0);
        set_load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
        step("lu_rs2_off", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);

        // Miss: three cycles without ack, then the ack cycle releases.
        clear_in();
        i_mem_req = 1'b1;
        step("miss1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 2'd0);
        step("miss2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 2'd1);
        i_mem_req = 1'b0;
        step("miss3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 2'd1);
        i_mem_ack = 1'b1;
        step("miss_ack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd1);
        clear_in();
        step("miss_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);

        i_mem_req = 1'b1;
        i_mem_ack = 1'b1;
        step("hit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);
        clear_in();
        step("hit_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);

        i_ex_redirect    = 1'b1;
        i_ex_redirect_pc = 64'h0000_0000_8000_0100;
        step("redir", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_0100, 2'd0);
        clear_in();
        step("redir_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);

        // Redirect arriving in the second of four wait cycles is held until the ack.
        i_mem_req = 1'b1;
        step("rw1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 2'd0);
        i_ex_redirect    = 1'b1;
        i_ex_redirect_pc = 64'h0000_0000_8000_0200;
        step("rw2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 2'd1);
        i_ex_redirect    = 1'b0;
        i_ex_redirect_pc = 64'h0000_0000_dead_0000;
        step("rw3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 2'd1);
        step("rw4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 2'd1);
        i_mem_ack = 1'b1;
        step("rw_ack", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_0200, 2'd1);
        clear_in();
        step("rw_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);

        set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        i_ex_redirect    = 1'b1;
        i_ex_redirect_pc = 64'h0000_0000_8000_0300;
        step("redir_lu", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_0300, 2'd0);
        clear_in();
        step("redir_lu_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);

        // Reset pulse in MEM_WAIT with a redirect pending, released between edges.
        i_mem_req = 1'b1;
        step("rst_w1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 2'd0);
        i_ex_redirect    = 1'b1;
        i_ex_redirect_pc = 64'h0000_0000_8000_0400;
        step("rst_w2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 2'd1);
        i_ex_redirect = 1'b0;
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 2'd1);
        #4;
        pop_check("rst_w3");
        #1;
        i_rst_n  = 1'b0;
        exp_scnt = 32'd0;
        exp_fcnt = 32'd0;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);
        #1;
        pop_check("rst_mid");
        clear_in();
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        step("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);
        step("rst_after2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
